// File: rtl/wb_defs.sv
// Shared definitions for the writeback stage: load-size encodings, FSM
// states and the layout of the WB control field carried down the pipeline.
package wb_defs;

  typedef enum logic [1:0] {
    LD_WORD = 2'b00,
    LD_HALF = 2'b01,
    LD_BYTE = 2'b10,
    LD_RSVD = 2'b11
  } ld_size_e;

  typedef enum logic {
    WB_RUN       = 1'b0,
    WB_WAIT_LOAD = 1'b1
  } wb_state_e;

  // Bit positions of the WB control field; identical in ID/EX and EX/MA.
  localparam int unsigned WB_REGWRITE  = 0;
  localparam int unsigned WB_MEMTOREG  = 1;
  localparam int unsigned WB_LDSIZE_LO = 2;
  localparam int unsigned WB_LDSIGNED  = 4;
  localparam int unsigned WB_CTRL_W    = 5;

  typedef logic [WB_CTRL_W-1:0] wb_ctrl_t;

  function automatic wb_ctrl_t pack_wb_ctrl(input logic       reg_write,
                                            input logic       mem_to_reg,
                                            input logic [1:0] ld_size,
                                            input logic       ld_signed);
    wb_ctrl_t c;
    c = '0;
    c[WB_REGWRITE]          = reg_write;
    c[WB_MEMTOREG]          = mem_to_reg;
    c[WB_LDSIZE_LO +: 2]    = ld_size;
    c[WB_LDSIGNED]          = ld_signed;
    return c;
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Little-endian load data alignment and sign/zero extension.
module load_formatter (
  input  logic [31:0] rdata,
  input  logic [1:0]  addrlo,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] data
);
  import wb_defs::*;

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Select the addressed byte/half and extend it to 32 bits.
  always_comb begin
    byte_val = rdata[{addrlo, 3'b000} +: 8];
    half_val = rdata[{addrlo[1], 4'b0000} +: 16];
    data     = rdata;
    case (ld_size_e'(size))
      LD_HALF: data = {{16{is_signed & half_val[15]}}, half_val};
      LD_BYTE: data = {{24{is_signed & byte_val[7]}}, byte_val};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MA/WB register, load-wait FSM with timeout, register-file
// write port, forward source and retire counter.
module wb_stage #(
  parameter int unsigned LOAD_TIMEOUT = 16,
  parameter bit          ZERO_REG_EN  = 1'b1
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        iValid,
  input  logic [4:0]  iRDS,
  input  logic [31:0] iALU,
  input  logic [1:0]  iAddrLo,
  input  logic        iRegWrite,
  input  logic        iMemToReg,
  input  logic [1:0]  iLdSize,
  input  logic        iLdSigned,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_rvalid,
  output logic        rf_we,
  output logic [4:0]  WAddr,
  output logic [31:0] WData,
  output logic        oFwdValid,
  output logic [4:0]  oFwdAddr,
  output logic [31:0] oFwdData,
  output logic        oStallReq,
  output logic        oBusErr,
  output logic [31:0] oRetireCnt
);
  import wb_defs::*;

  localparam int unsigned      CNT_W    = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

  wb_state_e        state, state_next;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;

  logic        valid;
  logic [4:0]  rd;
  logic [31:0] alu;
  logic [1:0]  addrlo;
  wb_ctrl_t    ctrl;

  logic        bus_err;
  logic [31:0] retire_cnt;

  logic        reg_write, mem_to_reg, ld_signed;
  logic [1:0]  ld_size;
  logic        completing, timeout, enter_wait, advance;
  logic [31:0] load_data, result;

  assign reg_write  = ctrl[WB_REGWRITE];
  assign mem_to_reg = ctrl[WB_MEMTOREG];
  assign ld_size    = ctrl[WB_LDSIZE_LO +: 2];
  assign ld_signed  = ctrl[WB_LDSIGNED];

  load_formatter u_fmt (
    .rdata     (dmem_rdata),
    .addrlo    (addrlo),
    .size      (ld_size),
    .is_signed (ld_signed),
    .data      (load_data)
  );

  // Next-state, completion, timeout and stall-request decode.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    completing    = 1'b0;
    timeout       = 1'b0;
    enter_wait    = 1'b0;
    oStallReq     = 1'b0;
    case (state)
      WB_RUN: begin
        if (valid) begin
          if (!mem_to_reg || dmem_rvalid) begin
            completing = 1'b1;
          end else begin
            enter_wait    = 1'b1;
            oStallReq     = 1'b1;
            state_next    = WB_WAIT_LOAD;
            wait_cnt_next = '0;
          end
        end
      end
      WB_WAIT_LOAD: begin
        if (dmem_rvalid) begin
          completing    = 1'b1;
          state_next    = WB_RUN;
          wait_cnt_next = '0;
        end else begin
          oStallReq = 1'b1;
          if (wait_cnt == CNT_LAST) begin
            timeout       = 1'b1;
            state_next    = WB_RUN;
            wait_cnt_next = '0;
          end else begin
            wait_cnt_next = wait_cnt + CNT_W'(1);
          end
        end
      end
      default: state_next = WB_RUN;
    endcase
  end

  // The register may only take a new bundle when no load is (or is about to
  // be) pending; the load that leaves WAIT_LOAD on rvalid frees it for MA,
  // which advances in that same cycle because oStallReq drops.
  assign advance = (state == WB_RUN && !enter_wait) ||
                   (state == WB_WAIT_LOAD && dmem_rvalid);

  // Register-file write port, mirrored onto the forward source.
  always_comb begin
    result = mem_to_reg ? load_data : alu;
    WAddr  = valid ? rd : '0;
    WData  = valid ? result : '0;
    rf_we  = completing & reg_write & ~(ZERO_REG_EN & (rd == 5'd0));
  end

  assign oFwdValid  = rf_we;
  assign oFwdAddr   = WAddr;
  assign oFwdData   = WData;
  assign oBusErr    = bus_err;
  assign oRetireCnt = retire_cnt;

  // FSM state, wait counter, bus-error pulse and retire counter.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state      <= WB_RUN;
      wait_cnt   <= '0;
      bus_err    <= 1'b0;
      retire_cnt <= '0;
    end else begin
      state      <= state_next;
      wait_cnt   <= wait_cnt_next;
      bus_err    <= timeout;
      retire_cnt <= retire_cnt + {31'b0, completing};
    end
  end

  // MA/WB register: flush beats stall; held while a load is outstanding.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      valid  <= 1'b0;
      rd     <= '0;
      alu    <= '0;
      addrlo <= '0;
      ctrl   <= '0;
    end else if (advance) begin
      if (flush) begin
        valid <= 1'b0;
      end else if (!stall) begin
        valid  <= iValid;
        rd     <= iRDS;
        alu    <= iALU;
        addrlo <= iAddrLo;
        ctrl   <= pack_wb_ctrl(iRegWrite, iMemToReg, iLdSize, iLdSigned);
      end else if (state == WB_WAIT_LOAD) begin
        valid <= 1'b0;
      end
    end else if (timeout) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage with randomized stimulus.
module tb_wb_stage;

  localparam int unsigned T = 4;

  logic        Clk, reset, stall, flush, iValid;
  logic [4:0]  iRDS;
  logic [31:0] iALU;
  logic [1:0]  iAddrLo;
  logic        iRegWrite, iMemToReg;
  logic [1:0]  iLdSize;
  logic        iLdSigned;
  logic [31:0] dmem_rdata;
  logic        dmem_rvalid;
  logic        rf_we;
  logic [4:0]  WAddr;
  logic [31:0] WData;
  logic        oFwdValid;
  logic [4:0]  oFwdAddr;
  logic [31:0] oFwdData;
  logic        oStallReq, oBusErr;
  logic [31:0] oRetireCnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_retire = '0;

  wb_stage #(.LOAD_TIMEOUT(T), .ZERO_REG_EN(1'b1)) dut (
    .Clk(Clk), .reset(reset), .stall(stall), .flush(flush), .iValid(iValid),
    .iRDS(iRDS), .iALU(iALU), .iAddrLo(iAddrLo), .iRegWrite(iRegWrite),
    .iMemToReg(iMemToReg), .iLdSize(iLdSize), .iLdSigned(iLdSigned),
    .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid), .rf_we(rf_we),
    .WAddr(WAddr), .WData(WData), .oFwdValid(oFwdValid), .oFwdAddr(oFwdAddr),
    .oFwdData(oFwdData), .oStallReq(oStallReq), .oBusErr(oBusErr),
    .oRetireCnt(oRetireCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference load formatting: shift the addressed lane down, mask, and
  // subtract 2^n when the sign bit is set.
  function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [1:0] a,
                                           input logic [1:0] sz, input logic sg);
    logic [31:0] v;
    case (sz)
      2'b10: begin
        v = (d >> (32'(a) * 8)) & 32'h0000_00FF;
        if (sg && v >= 32'h80) v = v - 32'h100;
      end
      2'b01: begin
        v = (d >> (32'(a[1]) * 16)) & 32'h0000_FFFF;
        if (sg && v >= 32'h8000) v = v - 32'h1_0000;
      end
      default: v = d;
    endcase
    return v;
  endfunction

  task automatic set_idle();
    iValid = 0; iRDS = '0; iALU = '0; iAddrLo = '0; iRegWrite = 0; iMemToReg = 0;
    iLdSize = '0; iLdSigned = 0; stall = 0; flush = 0; dmem_rvalid = 0;
  endtask

  task automatic set_op(input logic [4:0] r, input logic [31:0] a, input logic rw,
                        input logic m2r, input logic [1:0] al, input logic [1:0] sz,
                        input logic sg);
    iValid = 1; iRDS = r; iALU = a; iRegWrite = rw; iMemToReg = m2r;
    iAddrLo = al; iLdSize = sz; iLdSigned = sg; stall = 0; flush = 0;
  endtask

  task automatic test_reset();
    set_idle(); dmem_rdata = '0; reset = 0;
    repeat (2) @(negedge Clk);
    #1;
    n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL reset_rf_we: got %0b want 0", rf_we); end
    n_cmp++; if (WAddr !== 5'd0) begin n_bad++; $display("FAIL reset_waddr: got %0d want 0", WAddr); end
    n_cmp++; if (WData !== 32'd0) begin n_bad++; $display("FAIL reset_wdata: got %h want 0", WData); end
    n_cmp++; if (oStallReq !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %0b want 0", oStallReq); end
    n_cmp++; if (oBusErr !== 1'b0) begin n_bad++; $display("FAIL reset_buserr: got %0b want 0", oBusErr); end
    n_cmp++; if (oRetireCnt !== 32'd0) begin n_bad++; $display("FAIL reset_retire: got %0d want 0", oRetireCnt); end
    n_cmp++; if (oFwdValid !== 1'b0) begin n_bad++; $display("FAIL reset_fwd: got %0b want 0", oFwdValid); end
    @(negedge Clk); reset = 1;
    exp_retire = '0;
  endtask

  task automatic test_alu();
    logic [4:0] r; logic [31:0] a; logic rw, exp_we;
    for (int i = 0; i < 9; i++) begin
      if (i == 0) begin r = 5'd5; a = 32'h1234_5678; rw = 1; end
      else begin r = 5'($urandom_range(31, 1)); a = $urandom; rw = 1'($urandom); end
      @(negedge Clk); set_op(r, a, rw, 0, 2'($urandom), 2'($urandom), 1'($urandom));
      @(negedge Clk); set_idle(); #1;
      exp_we = rw;
      n_cmp++; if (rf_we !== exp_we) begin n_bad++; $display("FAIL alu_rf_we: got %0b want %0b", rf_we, exp_we); end
      n_cmp++; if (WAddr !== r) begin n_bad++; $display("FAIL alu_waddr: got %0d want %0d", WAddr, r); end
      n_cmp++; if (WData !== a) begin n_bad++; $display("FAIL alu_wdata: got %h want %h", WData, a); end
      n_cmp++; if (oFwdValid !== exp_we || oFwdAddr !== r || oFwdData !== a) begin
        n_bad++; $display("FAIL alu_fwd: got %0b/%0d/%h want %0b/%0d/%h", oFwdValid, oFwdAddr, oFwdData, exp_we, r, a);
      end
      n_cmp++; if (oStallReq !== 1'b0) begin n_bad++; $display("FAIL alu_stall: got %0b want 0", oStallReq); end
      exp_retire++;
      @(negedge Clk); #1;
      n_cmp++; if (oRetireCnt !== exp_retire) begin n_bad++; $display("FAIL alu_retire: got %0d want %0d", oRetireCnt, exp_retire); end
    end
  endtask

  task automatic test_load_now();
    logic [31:0] d, e; logic [1:0] a, sz; logic sg; logic [4:0] r;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin d = 32'h00A5_0000; a = 2; sz = 2'b10; sg = 1; end
        1: begin d = 32'h00A5_0000; a = 2; sz = 2'b10; sg = 0; end
        default: begin d = 32'h8001_0000; a = 2; sz = 2'b01; sg = 1; end
      endcase
      r = 5'($urandom_range(31, 1));
      e = ref_load(d, a, sz, sg);
      @(negedge Clk); set_op(r, $urandom, 1, 1, a, sz, sg);
      @(negedge Clk); set_idle(); dmem_rdata = d; dmem_rvalid = 1; #1;
      n_cmp++; if (rf_we !== 1'b1) begin n_bad++; $display("FAIL ldnow_rf_we: got %0b want 1", rf_we); end
      n_cmp++; if (WAddr !== r) begin n_bad++; $display("FAIL ldnow_waddr: got %0d want %0d", WAddr, r); end
      n_cmp++; if (WData !== e) begin n_bad++; $display("FAIL ldnow_wdata: got %h want %h", WData, e); end
      n_cmp++; if (oStallReq !== 1'b0) begin n_bad++; $display("FAIL ldnow_stall: got %0b want 0", oStallReq); end
      exp_retire++;
      @(negedge Clk); dmem_rvalid = 0; #1;
      n_cmp++; if (oRetireCnt !== exp_retire) begin n_bad++; $display("FAIL ldnow_retire: got %0d want %0d", oRetireCnt, exp_retire); end
    end
  endtask

  task automatic test_load_late();
    logic [31:0] d, e; logic [1:0] a, sz; logic sg; logic [4:0] r; int unsigned delay;
    for (int i = 0; i < 6; i++) begin
      delay = (i == 0) ? 3 : $urandom_range(T, 1);
      r = 5'($urandom_range(31, 1)); a = 2'($urandom); sz = 2'($urandom); sg = 1'($urandom);
      d = $urandom; e = ref_load(d, a, sz, sg);
      @(negedge Clk); set_op(r, $urandom, 1, 1, a, sz, sg); dmem_rvalid = 0;
      for (int k = 0; k < int'(delay); k++) begin
        @(negedge Clk);
        set_op(5'($urandom), $urandom, 1, 0, 2'($urandom), 2'($urandom), 1'($urandom));
        flush = (k % 2 == 1); stall = 1'($urandom); dmem_rvalid = 0; dmem_rdata = $urandom;
        #1;
        n_cmp++; if (oStallReq !== 1'b1) begin n_bad++; $display("FAIL late_stall: cyc %0d got %0b want 1", k, oStallReq); end
        n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL late_early_we: cyc %0d got %0b want 0", k, rf_we); end
        n_cmp++; if (WAddr !== r) begin n_bad++; $display("FAIL late_hold: cyc %0d got %0d want %0d", k, WAddr, r); end
      end
      @(negedge Clk); set_idle(); dmem_rdata = d; dmem_rvalid = 1; #1;
      n_cmp++; if (rf_we !== 1'b1) begin n_bad++; $display("FAIL late_rf_we: got %0b want 1", rf_we); end
      n_cmp++; if (WAddr !== r) begin n_bad++; $display("FAIL late_waddr: got %0d want %0d", WAddr, r); end
      n_cmp++; if (WData !== e) begin n_bad++; $display("FAIL late_wdata: got %h want %h", WData, e); end
      n_cmp++; if (oStallReq !== 1'b0) begin n_bad++; $display("FAIL late_stall_drop: got %0b want 0", oStallReq); end
      exp_retire++;
      @(negedge Clk); dmem_rvalid = 0; #1;
      n_cmp++; if (rf_we !== 1'b0 || WAddr !== 5'd0) begin n_bad++; $display("FAIL late_after: got we=%0b addr=%0d want 0/0", rf_we, WAddr); end
      n_cmp++; if (oRetireCnt !== exp_retire) begin n_bad++; $display("FAIL late_retire: got %0d want %0d", oRetireCnt, exp_retire); end
    end
  endtask

  task automatic test_timeout();
    logic [4:0] r;
    r = 5'($urandom_range(31, 1));
    @(negedge Clk); set_op(r, $urandom, 1, 1, 2'($urandom), 2'($urandom), 1'($urandom));
    // One RUN cycle plus T cycles in WAIT_LOAD before the entry is dropped.
    for (int k = 0; k <= int'(T); k++) begin
      @(negedge Clk); set_idle(); #1;
      n_cmp++; if (oStallReq !== 1'b1) begin n_bad++; $display("FAIL tmo_stall: cyc %0d got %0b want 1", k, oStallReq); end
      n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL tmo_we: cyc %0d got %0b want 0", k, rf_we); end
      n_cmp++; if (oBusErr !== 1'b0) begin n_bad++; $display("FAIL tmo_err_early: cyc %0d got %0b want 0", k, oBusErr); end
    end
    @(negedge Clk); set_idle(); dmem_rdata = $urandom; dmem_rvalid = 1; #1;
    n_cmp++; if (oBusErr !== 1'b1) begin n_bad++; $display("FAIL tmo_err: got %0b want 1", oBusErr); end
    n_cmp++; if (oStallReq !== 1'b0) begin n_bad++; $display("FAIL tmo_stall_drop: got %0b want 0", oStallReq); end
    n_cmp++; if (rf_we !== 1'b0 || WAddr !== 5'd0) begin n_bad++; $display("FAIL tmo_stray_rvalid: got we=%0b addr=%0d want 0/0", rf_we, WAddr); end
    n_cmp++; if (oRetireCnt !== exp_retire) begin n_bad++; $display("FAIL tmo_retire: got %0d want %0d", oRetireCnt, exp_retire); end
    @(negedge Clk); dmem_rvalid = 0; #1;
    n_cmp++; if (oBusErr !== 1'b0) begin n_bad++; $display("FAIL tmo_err_pulse: got %0b want 0", oBusErr); end
  endtask

  task automatic test_zero_reg();
    logic [31:0] a; logic [4:0] r;
    a = $urandom;
    @(negedge Clk); set_op(5'd0, a, 1, 0, 2'd0, 2'd0, 0);
    @(negedge Clk); set_idle(); #1;
    n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL zero_rf_we: got %0b want 0", rf_we); end
    n_cmp++; if (WData !== a) begin n_bad++; $display("FAIL zero_wdata: got %h want %h", WData, a); end
    exp_retire++;
    r = 5'($urandom_range(31, 1));
    @(negedge Clk); set_op(r, a, 0, 0, 2'd0, 2'd0, 0);
    @(negedge Clk); set_idle(); #1;
    n_cmp++; if (rf_we !== 1'b0 || WAddr !== r) begin n_bad++; $display("FAIL norw: got we=%0b addr=%0d want 0/%0d", rf_we, WAddr, r); end
    exp_retire++;
    @(negedge Clk); #1;
    n_cmp++; if (oRetireCnt !== exp_retire) begin n_bad++; $display("FAIL zero_retire: got %0d want %0d", oRetireCnt, exp_retire); end
  endtask

  task automatic test_flush_stall();
    logic [31:0] a; logic [4:0] r;
    a = $urandom; r = 5'($urandom_range(31, 1));
    @(negedge Clk); set_op(r, a, 1, 0, 2'd0, 2'd0, 0);
    @(negedge Clk); set_op(5'($urandom), $urandom, 1, 0, 2'd0, 2'd0, 0); flush = 1; stall = 1; #1;
    n_cmp++; if (rf_we !== 1'b1 || WAddr !== r || WData !== a) begin
      n_bad++; $display("FAIL fs_prev: got %0b/%0d/%h want 1/%0d/%h", rf_we, WAddr, WData, r, a);
    end
    exp_retire++;
    @(negedge Clk); set_idle(); #1;
    n_cmp++; if (rf_we !== 1'b0 || WAddr !== 5'd0 || WData !== 32'd0) begin
      n_bad++; $display("FAIL fs_bubble: got %0b/%0d/%h want 0/0/0", rf_we, WAddr, WData);
    end
    n_cmp++; if (oRetireCnt !== exp_retire) begin n_bad++; $display("FAIL fs_retire: got %0d want %0d", oRetireCnt, exp_retire); end
  endtask

  task automatic test_back_to_back();
    logic p_v, p_rw, p_m2r, p_sg, c_rw, c_m2r, c_sg, exp_we;
    logic [4:0] p_r, c_r; logic [31:0] p_a, c_a, d, e; logic [1:0] p_al, p_sz, c_al, c_sz;
    p_v = 0; p_rw = 0; p_m2r = 0; p_sg = 0; p_r = '0; p_a = '0; p_al = '0; p_sz = '0;
    for (int i = 0; i <= 12; i++) begin
      c_r = 5'($urandom); c_a = $urandom; c_rw = 1'($urandom); c_m2r = 1'($urandom);
      c_al = 2'($urandom); c_sz = 2'($urandom); c_sg = 1'($urandom);
      @(negedge Clk);
      if (i < 12) set_op(c_r, c_a, c_rw, c_m2r, c_al, c_sz, c_sg); else set_idle();
      d = $urandom; dmem_rdata = d;
      dmem_rvalid = p_m2r ? 1'b1 : 1'($urandom);
      #1;
      if (p_v) begin
        e = p_m2r ? ref_load(d, p_al, p_sz, p_sg) : p_a;
        exp_we = p_rw && (p_r != 5'd0);
        n_cmp++; if (rf_we !== exp_we || WAddr !== p_r || WData !== e) begin
          n_bad++; $display("FAIL b2b_write: op %0d got %0b/%0d/%h want %0b/%0d/%h", i, rf_we, WAddr, WData, exp_we, p_r, e);
        end
        n_cmp++; if (oStallReq !== 1'b0) begin n_bad++; $display("FAIL b2b_stall: op %0d got %0b want 0", i, oStallReq); end
        exp_retire++;
      end
      p_v = (i < 12); p_r = c_r; p_a = c_a; p_rw = c_rw; p_m2r = c_m2r; p_al = c_al; p_sz = c_sz; p_sg = c_sg;
    end
    @(negedge Clk); set_idle(); #1;
    n_cmp++; if (oRetireCnt !== exp_retire) begin n_bad++; $display("FAIL b2b_retire: got %0d want %0d", oRetireCnt, exp_retire); end
  endtask

  task automatic test_reset_wait();
    @(negedge Clk); set_op(5'($urandom_range(31, 1)), $urandom, 1, 1, 2'd0, 2'd0, 0);
    @(negedge Clk); set_idle();
    @(negedge Clk); #1;
    n_cmp++; if (oStallReq !== 1'b1) begin n_bad++; $display("FAIL rw_pending: got %0b want 1", oStallReq); end
    #1 reset = 0; #1;
    n_cmp++; if (oStallReq !== 1'b0) begin n_bad++; $display("FAIL rw_stall: got %0b want 0", oStallReq); end
    n_cmp++; if (rf_we !== 1'b0 || WAddr !== 5'd0 || WData !== 32'd0) begin
      n_bad++; $display("FAIL rw_port: got %0b/%0d/%h want 0/0/0", rf_we, WAddr, WData);
    end
    n_cmp++; if (oRetireCnt !== 32'd0 || oBusErr !== 1'b0) begin
      n_bad++; $display("FAIL rw_cnt: got %0d/%0b want 0/0", oRetireCnt, oBusErr);
    end
    exp_retire = '0;
    @(negedge Clk); reset = 1; dmem_rdata = $urandom; dmem_rvalid = 1; #1;
    n_cmp++; if (rf_we !== 1'b0 || WAddr !== 5'd0 || WData !== 32'd0 || oStallReq !== 1'b0) begin
      n_bad++; $display("FAIL rw_late_rvalid: got %0b/%0d/%h/%0b want 0/0/0/0", rf_we, WAddr, WData, oStallReq);
    end
    @(negedge Clk); dmem_rvalid = 0; #1;
    n_cmp++; if (oRetireCnt !== exp_retire) begin n_bad++; $display("FAIL rw_retire: got %0d want %0d", oRetireCnt, exp_retire); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_now();
    test_load_late();
    test_timeout();
    test_zero_reg();
    test_flush_stall();
    test_back_to_back();
    test_reset_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage at the far end of the pipeline: registers the MA/WB bundle from memory access and waits for load data from the data memory.
- Drives the register-file write port (rf_we, WAddr, WData) consumed by decode.
- Publishes the same write as a forward source for the forward unit.
- Raises a stall request while a load response is outstanding.

Parameters:
- LOAD_TIMEOUT, 16: max cycles spent in WAIT_LOAD before the entry is dropped with oBusErr.
- ZERO_REG_EN, 1: when 1, writes to register 0 are suppressed.

Ports:
- Clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hazard-unit stall; holds the MA/WB register.
- flush  in  1  loads an invalid bubble into the MA/WB register.
- iValid  in  1  MA-stage instruction valid.
- iRDS  in  5  destination register.
- iALU  in  32  ALU/PC result from MA.
- iAddrLo  in  2  low data-address bits of a load.
- iRegWrite  in  1  instruction writes rd.
- iMemToReg  in  1  result comes from a load.
- iLdSize  in  2  00 word, 01 half, 10 byte, 11 reserved (treated as word).
- iLdSigned  in  1  sign-extend a sub-word load.
- dmem_rdata  in  32  load data.
- dmem_rvalid  in  1  load data valid (one-cycle pulse).
- rf_we  out  1  register-file write enable.
- WAddr  out  5  register-file write address.
- WData  out  32  register-file write data.
- oFwdValid  out  1  equal to rf_we; forward source valid.
- oFwdAddr  out  5  equal to WAddr.
- oFwdData  out  32  equal to WData.
- oStallReq  out  1  upstream must hold; load outstanding.
- oBusErr  out  1  one-cycle pulse on load timeout.
- oRetireCnt  out  32  count of completed instructions; wraps.

Behaviour:
- Reset (reset=0, asynchronous):
  - entry valid, rdata capture flag and timeout counter cleared; FSM=RUN.
  - rf_we=0, WAddr=0, WData=0, oStallReq=0, oBusErr=0, oRetireCnt=0.
- MA/WB register:
  - Captures the i* bundle on the Clk rising edge when state=RUN and stall=0.
  - flush=1 (state=RUN) captures valid=0; flush has priority over stall.
  - In WAIT_LOAD the register holds regardless of stall or flush. The pending load is older than any flush source and is never aborted by flush.
- FSM states RUN and WAIT_LOAD:
  - Entry complete (RUN):
    - With valid=1 and MemToReg=0: the entry completes in the cycle it sits in the register.
    - With valid=1, MemToReg=1 and dmem_rvalid=1 in that cycle: the entry completes immediately.
  - Entering WAIT_LOAD:
    - RUN with valid=1, MemToReg=1 and dmem_rvalid=0 -> WAIT_LOAD at the next edge.
    - oStallReq=1 combinationally in that first cycle, and in every WAIT_LOAD cycle until completion.
  - WAIT_LOAD:
    - dmem_rvalid=1: the write occurs this cycle, oStallReq=0, then -> RUN and valid is cleared unless a new capture occurs.
    - Otherwise the counter increments.
  - Timeout:
    - Counter == LOAD_TIMEOUT-1 with no rvalid: oBusErr=1 for one cycle, no write, entry dropped, -> RUN, counter cleared.
    - rvalid and timeout in the same cycle: rvalid wins.
  - dmem_rvalid while no load is pending is ignored.
- Write port (combinational from the stage register and FSM):
  - rf_we = completing & RegWrite & !(ZERO_REG_EN & rd==0).
  - WAddr=rd and WData=result whenever the entry is valid; both are 0 otherwise.
  - Result is iALU for non-loads, or the formatted load data.
- Load formatting (little-endian):
  - byte = rdata[8*a+7:8*a].
  - half = rdata[16*a[1]+15:16*a[1]]; a[0] is ignored for half.
  - Sign- or zero-extended per iLdSigned.
- oRetireCnt increments by 1 at the edge after each completing cycle, including rd==0 and RegWrite=0 entries but excluding timeouts.
- oBusErr is registered: it pulses in the cycle after the timeout decision.
- Reset mid-WAIT_LOAD: pending load discarded, no write, oStallReq deasserted immediately.

Decomposition:
- Shared package wb_defs:
  - iLdSize encodings (LD_WORD, LD_HALF, LD_BYTE).
  - FSM state encoding (WB_RUN, WB_WAIT_LOAD).
  - WB control-field bit positions, so they line up with the WB field of the ID/EX and EX/MA buses.
- One combinational sub-module, load_formatter (rdata, addrlo, size, signed -> 32-bit data), instantiated once.

Test Plan:
- Reset release, then ALU op rd=5, iALU=0x12345678, RegWrite=1 -> one cycle later rf_we=1, WAddr=5, WData=0x12345678, oRetireCnt=1.
- Load byte signed, addrLo=2, rdata=0x00A50000, rvalid in the same cycle -> WData=0xFFFFFFA5, no stall. Repeat unsigned -> 0x000000A5. Half signed, addrLo=2, rdata=0x80010000 -> 0xFFFF8001.
- Load with rvalid 3 cycles late -> oStallReq high for 3 cycles, the MA/WB register ignores new inputs and flush, then a single write on the rvalid cycle.
- LOAD_TIMEOUT=4, rvalid never arrives -> oBusErr one-cycle pulse, rf_we never asserted, FSM returns to RUN, counter unchanged.
- ALU op rd=0 with RegWrite=1 -> rf_we=0, oRetireCnt increments. Also: flush and stall together in RUN -> the next cycle shows a bubble (rf_we=0).
- Assert reset during WAIT_LOAD, then rvalid after release -> no write, oStallReq=0, all outputs at reset values.
